// File: rtl/mips_pkg.sv
// Shared pipeline-control types: hazard FSM encoding, EX operand select codes, register-zero constant.
// Pure declarations, no logic.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01
  } hcu_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Per-stage match of the producing destination against each ID source operand.
  typedef struct packed {
    logic rs;
    logic rt;
  } dep_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard unit bundle: ID/EX/MEM/WB register info in, stall/flush/forward controls out.
// master = pipeline side, slave = hazard unit.
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_wr_reg;
  logic [4:0]       mem_wr_reg;
  logic [4:0]       wb_wr_reg;
  logic             ex_reg_write;
  logic             mem_reg_write;
  logic             wb_reg_write;
  logic             ex_mem_read;
  logic             mem_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             id_bypass_a;
  logic             id_bypass_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read, mem_branch_taken,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read, mem_branch_taken,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
           fwd_a, fwd_b, id_bypass_a, id_bypass_b, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_compare.sv
// RAW dependency check of one producing stage against the ID source operands.
// Purely combinational; writes to $0 never count as a dependency.
module hazard_compare
  import mips_pkg::*;
(
  input  logic       reg_write,
  input  logic [4:0] wr_reg,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output dep_t       match
);
  logic live;

  assign live     = reg_write && (wr_reg != REG_ZERO);
  assign match.rs = live && (wr_reg == rs);
  assign match.rt = live && uses_rt && (wr_reg == rt);
endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control: RAW stall FSM, taken-branch flush, EX forward selects and WB->ID bypass; counters saturate.
// Forwarding is built only with `HAZARD_FORWARDING_EN; stall/flush outputs are same-cycle, fwd selects load with ID-EX.
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_control_unit_if.slave hif
);

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  dep_t             ex_m, mem_m, wb_m;
  logic             ex_dep, mem_dep, wb_dep;
  logic [1:0]       n_req;
  hcu_state_t       state_q, state_nxt;
  logic [1:0]       rem_q, rem_nxt;
  logic             stall, bubble, branch;
  logic [1:0]       fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  hazard_compare u_cmp_ex (
    .reg_write(hif.ex_reg_write), .wr_reg(hif.ex_wr_reg),
    .rs(hif.id_rs), .rt(hif.id_rt), .uses_rt(hif.id_uses_rt), .match(ex_m)
  );
  hazard_compare u_cmp_mem (
    .reg_write(hif.mem_reg_write), .wr_reg(hif.mem_wr_reg),
    .rs(hif.id_rs), .rt(hif.id_rt), .uses_rt(hif.id_uses_rt), .match(mem_m)
  );
  hazard_compare u_cmp_wb (
    .reg_write(hif.wb_reg_write), .wr_reg(hif.wb_wr_reg),
    .rs(hif.id_rs), .rt(hif.id_rt), .uses_rt(hif.id_uses_rt), .match(wb_m)
  );

  assign ex_dep  = ex_m.rs  | ex_m.rt;
  assign mem_dep = mem_m.rs | mem_m.rt;
  assign wb_dep  = wb_m.rs  | wb_m.rt;
  assign branch  = hif.mem_branch_taken;

  // Bubbles needed before the ID instruction can read correct operands.
  always_comb begin
    n_req = 2'd0;
    if (FWD_EN) begin
      if (ex_dep && hif.ex_mem_read) n_req = 2'd1;
    end else if (ex_dep) begin
      n_req = 2'd3;
    end else if (mem_dep) begin
      n_req = 2'd2;
    end else if (wb_dep) begin
      n_req = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
    end
  end

  // rem_q counts bubbles still owed after the current one.
  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    if (branch) begin
      state_nxt = ST_RUN;
      rem_nxt   = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (n_req > 2'd1) begin
            state_nxt = ST_STALL;
            rem_nxt   = n_req - 2'd1;
          end
        end
        ST_STALL: begin
          if (rem_q <= 2'd1) begin
            state_nxt = ST_RUN;
            rem_nxt   = 2'd0;
          end else begin
            rem_nxt = rem_q - 2'd1;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Stalls are masked while reset is held and whenever a taken branch flushes.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_RUN:   stall = (n_req != 2'd0);
      ST_STALL: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
    bubble = stall && rst_n && !branch;
  end

  always_comb begin
    fwd_a_d = ex_m.rs ? FWD_EXMEM : (mem_m.rs ? FWD_MEMWB : FWD_RF);
    fwd_b_d = ex_m.rt ? FWD_EXMEM : (mem_m.rt ? FWD_MEMWB : FWD_RF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble || branch) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
      if (bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hif.pc_write    = !bubble;
  assign hif.ifid_write  = !bubble;
  assign hif.idex_bubble = bubble;
  assign hif.flush_ifid  = branch;
  assign hif.flush_idex  = branch;
  assign hif.flush_exmem = branch;
  assign hif.fwd_a       = FWD_EN ? fwd_a_q : FWD_RF;
  assign hif.fwd_b       = FWD_EN ? fwd_b_q : FWD_RF;
  assign hif.id_bypass_a = FWD_EN & wb_m.rs;
  assign hif.id_bypass_b = FWD_EN & wb_m.rt;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;
  assign hif.state       = state_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit; covers both builds of HAZARD_FORWARDING_EN.
// Narrow counters so saturation is reachable in a few cycles.
module tb_hazard_control_unit;
  import mips_pkg::*;

  localparam int CW = 4;
  // {pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem}
  localparam int C_RUN = 6'b110000;
  localparam int C_STL = 6'b001000;
  localparam int C_FLS = 6'b110111;

  typedef struct packed {
    logic [5:0]    ctl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          ba;
    logic          bb;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } obs_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  obs_t  exp_q[$];
  string name_q[$];

  hazard_control_unit_if #(.CNT_W(CW)) hif ();

  hazard_control_unit #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hif  (hif)
  );

  always #5 clk = ~clk;

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ctl = {hif.pc_write, hif.ifid_write, hif.idex_bubble,
             hif.flush_ifid, hif.flush_idex, hif.flush_exmem};
    o.fa  = hif.fwd_a;
    o.fb  = hif.fwd_b;
    o.ba  = hif.id_bypass_a;
    o.bb  = hif.id_bypass_b;
    o.st  = hif.state;
    o.sc  = hif.stall_cnt;
    o.fc  = hif.flush_cnt;
    return o;
  endfunction

  task automatic drive(input int rs, input int rt, input int urt,
                       input int exw, input int exrw, input int exmr,
                       input int memw, input int memrw,
                       input int wbw, input int wbrw, input int br);
    hif.id_rs            = 5'(rs);
    hif.id_rt            = 5'(rt);
    hif.id_uses_rt       = 1'(urt);
    hif.ex_wr_reg        = 5'(exw);
    hif.ex_reg_write     = 1'(exrw);
    hif.ex_mem_read      = 1'(exmr);
    hif.mem_wr_reg       = 5'(memw);
    hif.mem_reg_write    = 1'(memrw);
    hif.wb_wr_reg        = 5'(wbw);
    hif.wb_reg_write     = 1'(wbrw);
    hif.mem_branch_taken = 1'(br);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input int ctl, input int fa, input int fb,
                     input int ba, input int bb, input int st, input int sc, input int fc);
    obs_t e;
    e.ctl = 6'(ctl);
    e.fa  = 2'(fa);
    e.fb  = 2'(fb);
    e.ba  = 1'(ba);
    e.bb  = 1'(bb);
    e.st  = 2'(st);
    e.sc  = CW'(sc);
    e.fc  = CW'(fc);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    obs_t  e;
    obs_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got ctl=%b fwd=%b,%b byp=%b%b state=%b sc=%0d fc=%0d ; want ctl=%b fwd=%b,%b byp=%b%b state=%b sc=%0d fc=%0d",
                   nm, a.ctl, a.fa, a.fb, a.ba, a.bb, a.st, a.sc, a.fc,
                   e.ctl, e.fa, e.fb, e.ba, e.bb, e.st, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : stim
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset held: stall request must be masked, branch still flushes.
    drive(2, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    cyc("rst_mask", C_RUN, 0, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 2, 1, 1, 0, 0, 0, 0, 1);
    cyc("rst_branch", C_FLS, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    drive(0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0);
    cyc("zero_dst", C_RUN, 0, 0, 0, 0, 0, 0, 0);

`ifdef HAZARD_FORWARDING_EN
    drive(2, 4, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    cyc("lw_bubble", C_STL, 0, 0, 0, 0, 0, 0, 0);
    drive(2, 4, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    cyc("lw_release", C_RUN, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc("lw_fwd", C_RUN, 2, 0, 0, 0, 0, 1, 0);

    drive(2, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    cyc("add_nostall", C_RUN, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc("add_fwd", C_RUN, 1, 1, 0, 0, 0, 1, 0);

    drive(3, 6, 1, 3, 1, 0, 6, 1, 0, 0, 0);
    cyc("mix_issue", C_RUN, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc("mix_fwd", C_RUN, 1, 2, 0, 0, 0, 1, 0);
    drive(3, 6, 0, 3, 0, 0, 3, 1, 0, 0, 0);
    cyc("rw_off_issue", C_RUN, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc("rw_off_fwd", C_RUN, 2, 0, 0, 0, 0, 1, 0);

    drive(10, 10, 0, 0, 0, 0, 0, 0, 10, 1, 0);
    cyc("byp_a", C_RUN, 0, 0, 1, 0, 0, 1, 0);
    drive(9, 10, 1, 0, 0, 0, 0, 0, 10, 1, 0);
    cyc("byp_b", C_RUN, 0, 0, 0, 1, 0, 1, 0);

    drive(2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1);
    cyc("br_fwd_clear", C_FLS, 0, 0, 0, 0, 0, 1, 0);
    idle();
    cyc("br_after", C_RUN, 0, 0, 0, 0, 0, 1, 1);
    drive(2, 0, 0, 2, 1, 1, 0, 0, 0, 0, 1);
    cyc("br_over_lw", C_FLS, 0, 0, 0, 0, 0, 1, 1);
    idle();
    cyc("br_over_lw_after", C_RUN, 0, 0, 0, 0, 0, 1, 2);

    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
      cyc("stall_sat", C_STL, 0, 0, 0, 0, 0, mn(1 + i, 15), 2);
    end
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("flush_sat", C_FLS, 0, 0, 0, 0, 0, 15, mn(2 + i, 15));
    end
    idle();
    cyc("sat_hold", C_RUN, 0, 0, 0, 0, 0, 15, 15);

    drive(2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    cyc("rst_setup", C_RUN, 0, 0, 0, 0, 0, 15, 15);
    rst_n = 1'b0;
    idle();
    cyc("rst_clear", C_RUN, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(2, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    cyc("rst_resume", C_STL, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc("rst_after", C_RUN, 0, 0, 0, 0, 0, 1, 0);
`else
    drive(2, 4, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    cyc("ex_b1", C_STL, 0, 0, 0, 0, 0, 0, 0);
    drive(2, 4, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    cyc("ex_b2", C_STL, 0, 0, 0, 0, 1, 1, 0);
    drive(2, 4, 1, 0, 0, 0, 0, 0, 2, 1, 0);
    cyc("ex_b3", C_STL, 0, 0, 0, 0, 1, 2, 0);
    drive(2, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ex_run", C_RUN, 0, 0, 0, 0, 0, 3, 0);

    drive(5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cyc("mem_b1", C_STL, 0, 0, 0, 0, 0, 3, 0);
    drive(5, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0);
    cyc("mem_b2", C_STL, 0, 0, 0, 0, 1, 4, 0);
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mem_run", C_RUN, 0, 0, 0, 0, 0, 5, 0);

    drive(0, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0);
    cyc("rt_unused", C_RUN, 0, 0, 0, 0, 0, 5, 0);
    drive(0, 7, 1, 0, 0, 0, 0, 0, 7, 1, 0);
    cyc("wb_b1", C_STL, 0, 0, 0, 0, 0, 5, 0);
    idle();
    cyc("wb_run", C_RUN, 0, 0, 0, 0, 0, 6, 0);

    drive(3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc("br_b1", C_STL, 0, 0, 0, 0, 0, 6, 0);
    drive(3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
    cyc("br_abort", C_FLS, 0, 0, 0, 0, 1, 7, 0);
    idle();
    cyc("br_run", C_RUN, 0, 0, 0, 0, 0, 7, 1);

    drive(3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
    cyc("br_prio", C_FLS, 0, 0, 0, 0, 0, 7, 1);
    idle();
    cyc("br_after", C_RUN, 0, 0, 0, 0, 0, 7, 2);

    for (int i = 0; i < 10; i++) begin
      drive(0, 7, 1, 0, 0, 0, 0, 0, 7, 1, 0);
      cyc("stall_sat", C_STL, 0, 0, 0, 0, 0, mn(7 + i, 15), 2);
    end
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("flush_sat", C_FLS, 0, 0, 0, 0, 0, 15, mn(2 + i, 15));
    end
    idle();
    cyc("sat_hold", C_RUN, 0, 0, 0, 0, 0, 15, 15);

    drive(3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc("rst_b1", C_STL, 0, 0, 0, 0, 0, 15, 15);
    drive(3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cyc("rst_b2", C_STL, 0, 0, 0, 0, 1, 15, 15);
    rst_n = 1'b0;
    drive(3, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
    cyc("rst_mid_stall", C_RUN, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 7, 1, 0, 0, 0, 0, 0, 7, 1, 0);
    cyc("rst_resume", C_STL, 0, 0, 0, 0, 0, 0, 0);
    idle();
    cyc("rst_after", C_RUN, 0, 0, 0, 0, 0, 1, 0);
`endif

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
